// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered 32-bit ALU between two valid/ready requesters.
// Round-robin by default; define ALU_ARB_FIXED_PRIO_EN to give requester 0 fixed priority.
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_src1,
    input  logic [63:0] req_src2,
    input  logic [7:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_cout,
    output logic        rsp_overflow,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_cout,
    input  logic        alu_overflow,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic       op_id;
    logic       grant;
    logic       grant_valid;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic       last_grant;
`endif

    // A lone valid requester always wins; a conflict goes to the one not served last.
    always_comb begin
        grant       = 1'b0;
        grant_valid = |req_valid;
        if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~last_grant;
`endif
        end else begin
            grant = req_valid[1];
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 2'b00;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    req_ready[grant] = 1'b1;
                    state_next       = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // ALU operands stay frozen from the accept edge until the next accepted request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            op_id        <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_cout     <= 1'b0;
            rsp_overflow <= 1'b0;
            alu_src1     <= '0;
            alu_src2     <= '0;
            alu_ctrl     <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        alu_src1 <= grant ? req_src1[63:32] : req_src1[31:0];
                        alu_src2 <= grant ? req_src2[63:32] : req_src2[31:0];
                        alu_ctrl <= grant ? req_op[7:4] : req_op[3:0];
                        op_id    <= grant;
                        cnt      <= LAT_INIT;
                    end
                end
                EXEC: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rsp_valid    <= 1'b1;
                        rsp_id       <= op_id;
                        rsp_result   <= alu_result;
                        rsp_zero     <= alu_zero;
                        rsp_cout     <= alu_cout;
                        rsp_overflow <= alu_overflow;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && grant_valid) begin
            last_grant <= grant;
        end
    end
`endif

endmodule
